// File: rtl/switch_pkg.sv
//==============================================================================
// Module   : switch_pkg
// Brief    : Shared constants and enumerations for the 4-port switch ingress.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package switch_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 4;
    localparam int MIN_PKT   = 4;
    localparam int PORT_W    = $clog2(NUM_PORTS);
    localparam int CNT_W     = $clog2(MIN_PKT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } ingress_state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        NO_MATCH = 2'd1,
        Q_FULL   = 2'd2,
        PARTIAL  = 2'd3
    } drop_cause_e;

endpackage

`default_nettype wire

// File: rtl/switch_addr_match.sv
//==============================================================================
// Module   : switch_addr_match
// Brief    : Combinational DA compare against the port address registers with
//            lowest-index priority resolution.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_addr_match
    import switch_pkg::*;
(
    input  logic [DATA_W-1:0]                  i_da,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]   i_addr,
    output logic [NUM_PORTS-1:0]               o_hit_vec,
    output logic                               o_hit,
    output logic [PORT_W-1:0]                  o_hit_idx
);

    logic [NUM_PORTS-1:0] w_eq;

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cmp
            assign w_eq[g] = (i_addr[g] == i_da);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        o_hit_vec = '0;
        o_hit_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                o_hit_vec    = '0;
                o_hit_vec[i] = 1'b1;
                o_hit_idx    = PORT_W'(i);
            end
        end
    end

    assign o_hit = |w_eq;

endmodule

`default_nettype wire

// File: rtl/switch_ingress_ctrl.sv
//==============================================================================
// Module   : switch_ingress_ctrl
// Brief    : Ingress controller: port address registers, packet parse, DA match
//            and steering into one output queue or drop.
//            Optional macro SWITCH_PARITY_CHECK_EN adds an XOR parity check.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_ingress_ctrl
    import switch_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  mem_en,
    input  logic                  mem_rd_wr,
    input  logic [PORT_W-1:0]     mem_add,
    input  logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W-1:0]     mem_rdata,
    input  logic [DATA_W-1:0]     data,
    input  logic                  data_status,
    input  logic [NUM_PORTS-1:0]  q_space_ok,
    output logic [NUM_PORTS-1:0]  q_wr_en,
    output logic [DATA_W-1:0]     q_wr_data,
    output logic                  q_sop,
    output logic                  q_eop,
    output logic                  q_bad,
    output logic                  pkt_drop,
    output logic [1:0]            drop_cause
);

    logic [NUM_PORTS-1:0][DATA_W-1:0] r_addr;
    logic [DATA_W-1:0]                r_mem_rdata;

    ingress_state_e                   r_state;
    ingress_state_e                   w_state_nxt;
    drop_cause_e                      r_cause;
    drop_cause_e                      w_cause_nxt;
    logic                             w_load_cause;

    logic                             r_armed;
    logic                             r_prev_ds;
    logic                             w_sop;
    logic                             w_accept;

    logic [NUM_PORTS-1:0]             w_hit_vec;
    logic                             w_hit;
    logic [PORT_W-1:0]                w_hit_idx;

    logic [NUM_PORTS-1:0]             r_dest;
    logic [NUM_PORTS-1:0]             r_wr_en;
    logic [DATA_W-1:0]                r_wr_data;
    logic                             r_sop;
    logic                             r_valid;
    logic [CNT_W-1:0]                 r_cnt;
    logic                             w_par_bad;

    // Address registers; reads see the value before a same-cycle write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_addr[i] <= DATA_W'(i);
            end
            r_mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_rd_wr) begin
                r_addr[mem_add] <= mem_data;
            end else begin
                r_mem_rdata <= r_addr[mem_add];
            end
        end
    end

    assign mem_rdata = r_mem_rdata;

    switch_addr_match u_match (
        .i_da      (data),
        .i_addr    (r_addr),
        .o_hit_vec (w_hit_vec),
        .o_hit     (w_hit),
        .o_hit_idx (w_hit_idx)
    );

    assign w_sop = data_status & ~r_prev_ds & r_armed;

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_load_cause = 1'b0;
        w_cause_nxt  = NONE;
        case (r_state)
            IDLE: begin
                // Unarmed with data present means a packet straddled reset.
                if (!r_armed && data_status) begin
                    w_state_nxt  = DROP;
                    w_load_cause = 1'b1;
                    w_cause_nxt  = PARTIAL;
                end else if (w_sop) begin
                    if (!w_hit) begin
                        w_state_nxt  = DROP;
                        w_load_cause = 1'b1;
                        w_cause_nxt  = NO_MATCH;
                    end else if (!q_space_ok[w_hit_idx]) begin
                        w_state_nxt  = DROP;
                        w_load_cause = 1'b1;
                        w_cause_nxt  = Q_FULL;
                    end else begin
                        w_state_nxt = FWD;
                        w_accept    = 1'b1;
                    end
                end
            end
            FWD: begin
                if (data_status) begin
                    w_accept = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (!data_status) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cause   <= NONE;
            r_armed   <= 1'b0;
            r_prev_ds <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_armed   <= r_armed | ~data_status;
            r_prev_ds <= data_status;
            if (w_load_cause) begin
                r_cause <= w_cause_nxt;
            end
        end
    end

    // One-cycle forwarding pipeline plus length counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dest    <= '0;
            r_wr_en   <= '0;
            r_wr_data <= '0;
            r_sop     <= 1'b0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_valid <= w_accept;
            r_sop   <= w_accept & (r_state == IDLE);
            if (w_accept) begin
                r_wr_data <= data;
                if (r_state == IDLE) begin
                    r_dest  <= w_hit_vec;
                    r_wr_en <= w_hit_vec;
                    r_cnt   <= CNT_W'(1);
                end else begin
                    r_wr_en <= r_dest;
                    if (r_cnt != CNT_W'(MIN_PKT)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end else begin
                r_wr_en <= '0;
            end
        end
    end

`ifdef SWITCH_PARITY_CHECK_EN
    logic [DATA_W-1:0] r_par;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_par <= '0;
        end else if (w_accept) begin
            r_par <= (r_state == IDLE) ? data : (r_par ^ data);
        end
    end

    assign w_par_bad = |r_par;
`else
    assign w_par_bad = 1'b0;
`endif

    assign q_wr_en    = r_wr_en;
    assign q_wr_data  = r_wr_data;
    assign q_sop      = r_sop;
    assign q_eop      = r_valid & ~data_status;
    assign q_bad      = q_eop & ((r_cnt < CNT_W'(MIN_PKT)) | w_par_bad);
    assign pkt_drop   = (r_state == DROP) & ~data_status;
    assign drop_cause = pkt_drop ? r_cause : NONE;

endmodule

`default_nettype wire
